// File: rtl/serial_host_seq_if.sv
// Request/response handshake and shared serial line of the serial host sequencer.
// The slave side is the sequencer; the master side is the host plus the line model.
interface serial_host_seq_if #(
    parameter int DATA_LEN = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [DATA_LEN-1:0] req_wdata;
    logic                rsp_valid;
    logic [DATA_LEN-1:0] rsp_rdata;
    logic                line_out;
    logic                line_oe;
    logic                line_in;

    modport master (
        output req_valid, req_op, req_wdata, line_in,
        input  req_ready, rsp_valid, rsp_rdata, line_out, line_oe
    );

    modport slave (
        input  req_valid, req_op, req_wdata, line_in,
        output req_ready, rsp_valid, rsp_rdata, line_out, line_oe
    );
endinterface

// File: rtl/serial_host_seq.sv
// Serial host sequencer: frames RESET/WRITE/UPDATE/READ requests onto a shared
// half-duplex line (start bit, command, payload or turnaround + receive).
module serial_host_seq #(
    parameter int                 CMD_LEN       = 4,
    parameter int                 DATA_LEN      = 8,
    parameter logic [CMD_LEN-1:0] RESET_CMD     = CMD_LEN'(1),
    parameter logic [CMD_LEN-1:0] START_RCV_CMD = CMD_LEN'(2),
    parameter logic [CMD_LEN-1:0] UPDATE_CMD    = CMD_LEN'(3),
    parameter logic [CMD_LEN-1:0] START_SND_CMD = CMD_LEN'(4)
) (
    input logic              clk,
    input logic              rst_n,
    serial_host_seq_if.slave bus
);
    localparam int MAX_CD  = (CMD_LEN > DATA_LEN) ? CMD_LEN : DATA_LEN;
    localparam int MAX_LEN = (MAX_CD > 4) ? MAX_CD : 4;
    localparam int CNT_W   = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CMD, S_CMD_END, S_PRE, S_DATA, S_DATA_END,
        S_TURN, S_RX_WAIT, S_RX, S_RX_END, S_POST
    } state_e;

    typedef enum logic [1:0] {
        OP_RESET  = 2'd0,
        OP_WRITE  = 2'd1,
        OP_UPDATE = 2'd2,
        OP_READ   = 2'd3
    } op_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q;
    logic [CMD_LEN-1:0]  cmd_sh;
    logic [DATA_LEN-1:0] data_sh;
    logic                ready_en;
    logic                rsp_valid_q;
    logic [DATA_LEN-1:0] rsp_rdata_q;
    logic                ready;
    logic                line_out;
    logic                line_oe;
    logic                accept;
    logic                done;

    function automatic logic [CMD_LEN-1:0] cmd_for(input op_e op);
        logic [CMD_LEN-1:0] cmd;
        cmd = RESET_CMD;
        case (op)
            OP_WRITE:  cmd = START_RCV_CMD;
            OP_UPDATE: cmd = UPDATE_CMD;
            OP_READ:   cmd = START_SND_CMD;
            default:   cmd = RESET_CMD;
        endcase
        return cmd;
    endfunction

    assign accept = bus.req_valid && ready;
    assign done   = (state_q == S_POST) && (cnt_q == '0);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_START;
            S_START: begin
                state_d = S_CMD;
                cnt_d   = CMD_LAST;
            end
            S_CMD:      if (cnt_q == '0) state_d = S_CMD_END; else cnt_d = cnt_q - 1'b1;
            S_CMD_END: begin
                case (op_q)
                    OP_WRITE: state_d = S_PRE;
                    OP_READ: begin
                        state_d = S_TURN;
                        cnt_d   = CNT_W'(1);
                    end
                    default: begin
                        state_d = S_POST;
                        cnt_d   = CNT_W'(3);
                    end
                endcase
            end
            S_PRE: begin
                state_d = S_DATA;
                cnt_d   = DATA_LAST;
            end
            S_DATA:     if (cnt_q == '0) state_d = S_DATA_END; else cnt_d = cnt_q - 1'b1;
            S_DATA_END: begin
                state_d = S_POST;
                cnt_d   = CNT_W'(2);
            end
            S_TURN:     if (cnt_q == '0) state_d = S_RX_WAIT; else cnt_d = cnt_q - 1'b1;
            S_RX_WAIT: begin
                state_d = S_RX;
                cnt_d   = DATA_LAST;
            end
            S_RX:       if (cnt_q == '0) state_d = S_RX_END; else cnt_d = cnt_q - 1'b1;
            S_RX_END: begin
                state_d = S_POST;
                cnt_d   = CNT_W'(1);
            end
            S_POST:     if (cnt_q == '0) state_d = S_IDLE; else cnt_d = cnt_q - 1'b1;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // data_sh serializes the write payload and later collects the read word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_RESET;
            cmd_sh      <= '0;
            data_sh     <= '0;
            ready_en    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ready_en    <= 1'b1;
            rsp_valid_q <= done;
            if (done && (op_q == OP_READ)) rsp_rdata_q <= data_sh;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= op_e'(bus.req_op);
                        cmd_sh  <= cmd_for(op_e'(bus.req_op));
                        data_sh <= bus.req_wdata;
                    end
                end
                S_CMD:   cmd_sh  <= cmd_sh << 1;
                S_DATA:  data_sh <= data_sh << 1;
                S_RX:    data_sh <= (data_sh << 1) | DATA_LEN'(bus.line_in);
                default: ;
            endcase
        end
    end

    // Line is released only while the target answers a READ.
    always_comb begin
        ready    = ready_en && (state_q == S_IDLE);
        line_oe  = 1'b1;
        line_out = 1'b0;
        case (state_q)
            S_START:                   line_out = 1'b1;
            S_CMD:                     line_out = cmd_sh[CMD_LEN-1];
            S_DATA:                    line_out = data_sh[DATA_LEN-1];
            S_RX_WAIT, S_RX, S_RX_END: line_oe  = 1'b0;
            default: ;
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.line_out  = line_out;
    assign bus.line_oe   = line_oe;
endmodule

// File: doc/serial_host_seq.md
SERIAL_HOST_SEQ -- requirements
Module: serial_host_seq

Interface
REQ-001 Parameter: CMD_LEN, default 4, command field width in bits.
REQ-002 Parameter: DATA_LEN, default 8, data field width in bits.
REQ-003 Parameters: RESET_CMD / START_RCV_CMD / UPDATE_CMD / START_SND_CMD, defaults 1 / 2 / 3 / 4, CMD_LEN-bit command encodings.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: req_valid  in  1  request offered.
REQ-007 Port: req_ready  out  1  sequencer can accept a request.
REQ-008 Port: req_op  in  2  operation: 0 RESET, 1 WRITE, 2 UPDATE, 3 READ.
REQ-009 Port: req_wdata  in  DATA_LEN  write payload; used for WRITE only.
REQ-010 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  out  DATA_LEN  read result; updated on READ completion only.
REQ-012 Port: line_out  out  1  value driven onto the shared serial line.
REQ-013 Port: line_oe  out  1  1 = drive line_out onto the line, 0 = release it.
REQ-014 Port: line_in  in  1  line value (same clock domain); no synchroniser.

Function
REQ-015 Handshake: request accepted on a rising edge with req_valid=1 and req_ready=1; req_op and req_wdata are captured then and held internally.
REQ-016 req_ready SHALL be 1 only in IDLE; it is 0 from the cycle after acceptance until the rsp_valid cycle, inclusive of that cycle's return to IDLE.
REQ-017 States: IDLE, START, CMD, CMD_END, PRE, DATA, DATA_END, TURN, RX_WAIT, RX, RX_END, POST; a down-counter sized for max(CMD_LEN, DATA_LEN, 4) sequences multi-cycle states.
REQ-018 Cycle numbering: cycle 0 is the accepting edge; outputs are registered, so cycle n is the n-th clock period after it.
REQ-019 All ops: cycle 1 START drives line_out=1; cycles 2..CMD_LEN+1 CMD drives the command MSB first; next cycle CMD_END drives 0.
REQ-020 WRITE: command START_RCV_CMD; then PRE 1 cycle at 0; DATA DATA_LEN cycles, req_wdata MSB first; DATA_END 1 cycle at 0; POST 3 cycles at 0.
REQ-021 RESET and UPDATE: command RESET_CMD or UPDATE_CMD; then POST 4 cycles at 0.
REQ-022 READ: command START_SND_CMD; TURN 2 cycles, line_oe=1, line_out=0; line_oe=0 from RX_WAIT through RX_END.
REQ-023 READ, continued: RX_WAIT 1 cycle; RX DATA_LEN cycles, line_in sampled at the rising edge ending each RX cycle, MSB first; RX_END 1 cycle; POST 2 cycles with line_oe=1, line_out=0.
REQ-024 After POST: rsp_valid=1 for exactly one cycle while the block is in IDLE; for READ, rsp_rdata is loaded with the sampled word on that cycle.
REQ-025 line_oe SHALL be 1 in every state except RX_WAIT, RX and RX_END; line_out SHALL be 0 whenever no bit is specified above.
REQ-026 Latency with defaults, accept to rsp_valid: WRITE 20, RESET 11, UPDATE 11, READ 21 cycles.
REQ-027 Payload corner cases: req_wdata of all-zeros or all-ones is serialized verbatim; no bit stuffing, parity or framing besides the start bit.
REQ-028 req_valid held high across completion: the next request is accepted on the rsp_valid cycle edge, giving back-to-back operation with no idle gap.
REQ-029 Unsupported conditions: req_op and req_wdata changes while busy are ignored; there is no error output.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, counters 0, req_ready=0 while low, rsp_valid=0, rsp_rdata=0, line_oe=1, line_out=0.
REQ-031 Reset asserted mid-operation SHALL abort it without a rsp_valid pulse; line_oe returns to 1 immediately, even during RX.
REQ-032 req_ready SHALL rise on the first rising edge after rst_n deasserts.

Verification
REQ-033 RESET op -> line_out sequence 1,0,0,0,1,0 over cycles 1-6, then 0 for 4 cycles; rsp_valid at cycle 11; line_oe=1 throughout.
REQ-034 WRITE 8'hA5 -> cycles 1-6 are 1,0,0,1,0,0; cycle 7 is 0; cycles 8-15 are 1,0,1,0,0,1,0,1; rsp_valid at cycle 20.
REQ-035 READ with line model driving 8'h3C MSB first in cycles 10-17 -> line_oe=0 over cycles 9-18; rsp_rdata=8'h3C at cycle 21; rsp_rdata unchanged by a following WRITE.
REQ-036 req_valid held high for WRITE 8'h00, UPDATE, READ -> each accepted on the previous rsp_valid cycle; req_ready=0 otherwise.
REQ-037 rst_n pulsed low at cycle 12 of READ -> line_oe=1 the same cycle, no rsp_valid; after release a WRITE 8'hFF completes normally.
